// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - mode-0 SPI responder with oversampled cs/sck/mosi and fixed-length frames
module spi_slave #(
    parameter int SIZE = 40
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [SIZE-1:0] tx_bytes,
    input  logic            tx_load,
    output logic [SIZE-1:0] rx_bytes,
    output logic            rx_valid,
    output logic            frame_err,
    output logic            busy,
    input  logic            cs,
    input  logic            sck,
    input  logic            mosi,
    output logic            miso
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic [5:0] LAST_BIT  = 6'(SIZE);
    localparam logic [1:0] SETTLED   = 2'd2;

    // input synchronisers and edge-history flops
    logic cs_s1_q,   cs_s1_d;
    logic cs_s2_q,   cs_s2_d;
    logic cs_h_q,    cs_h_d;
    logic sck_s1_q,  sck_s1_d;
    logic sck_s2_q,  sck_s2_d;
    logic sck_h_q,   sck_h_d;
    logic mosi_s1_q, mosi_s1_d;
    logic mosi_s2_q, mosi_s2_d;

    // cs must be seen high after reset before a frame may start
    logic [1:0] settle_q, settle_d;
    logic       armed_q,  armed_d;

    // frame state
    logic [1:0]      state_q,    state_d;
    logic [5:0]      cnt_q,      cnt_d;
    logic [SIZE-1:0] pend_q,     pend_d;
    logic [SIZE-1:0] tx_sr_q,    tx_sr_d;
    logic [SIZE-2:0] rx_sr_q,    rx_sr_d;
    logic [SIZE-1:0] rx_bytes_q, rx_bytes_d;
    logic            rx_valid_q, rx_valid_d;
    logic            frame_err_q, frame_err_d;

    logic            cs_fall;
    logic            cs_rise;
    logic            sck_rise;
    logic            sck_fall;
    logic [5:0]      cnt_inc;
    logic [SIZE-1:0] rx_cat;

    assign cs_fall  = cs_h_q & ~cs_s2_q;
    assign cs_rise  = ~cs_h_q & cs_s2_q;
    assign sck_rise = ~sck_h_q & sck_s2_q;
    assign sck_fall = sck_h_q & ~sck_s2_q;
    assign cnt_inc  = cnt_q + 6'd1;
    assign rx_cat   = {rx_sr_q, mosi_s2_q};

    // synchroniser pipeline and post-reset arming of the cs falling-edge detector
    always_comb begin
        cs_s1_d   = cs;
        cs_s2_d   = cs_s1_q;
        cs_h_d    = cs_s2_q;
        sck_s1_d  = sck;
        sck_s2_d  = sck_s1_q;
        sck_h_d   = sck_s2_q;
        mosi_s1_d = mosi;
        mosi_s2_d = mosi_s1_q;
        settle_d  = (settle_q == SETTLED) ? settle_q : settle_q + 2'd1;
        armed_d   = armed_q | ((settle_q == SETTLED) & cs_s2_q);
    end

    // frame state machine; the shift-out MSB is miso, so clearing it silences the line
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        tx_sr_d     = tx_sr_q;
        rx_sr_d     = rx_sr_q;
        rx_bytes_d  = rx_bytes_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;

        if (tx_load) begin
            pend_d = tx_bytes;
        end

        case (state_q)
            ST_IDLE: begin
                tx_sr_d = '0;
                if (cs_fall && armed_q) begin
                    state_d = ST_ACTIVE;
                    tx_sr_d = pend_q;
                    cnt_d   = '0;
                end
            end
            ST_ACTIVE: begin
                if (cs_rise) begin
                    // deselect always wins over a coincident sck edge
                    state_d     = ST_IDLE;
                    tx_sr_d     = '0;
                    frame_err_d = 1'b1;
                end else if (sck_rise) begin
                    rx_sr_d = rx_cat[SIZE-2:0];
                    cnt_d   = cnt_inc;
                    if (cnt_inc == LAST_BIT) begin
                        rx_bytes_d = rx_cat;
                        rx_valid_d = 1'b1;
                        state_d    = ST_DONE;
                        tx_sr_d    = '0;
                    end
                end else if (sck_fall && (cnt_q != 6'd0)) begin
                    tx_sr_d = {tx_sr_q[SIZE-2:0], 1'b0};
                end
            end
            ST_DONE: begin
                tx_sr_d = '0;
                if (cs_rise) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_sr_d = '0;
            end
        endcase
    end

    // all state registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            cs_s1_q     <= 1'b1;
            cs_s2_q     <= 1'b1;
            cs_h_q      <= 1'b1;
            sck_s1_q    <= 1'b0;
            sck_s2_q    <= 1'b0;
            sck_h_q     <= 1'b0;
            mosi_s1_q   <= 1'b0;
            mosi_s2_q   <= 1'b0;
            settle_q    <= '0;
            armed_q     <= 1'b0;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            pend_q      <= '0;
            tx_sr_q     <= '0;
            rx_sr_q     <= '0;
            rx_bytes_q  <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            cs_s1_q     <= cs_s1_d;
            cs_s2_q     <= cs_s2_d;
            cs_h_q      <= cs_h_d;
            sck_s1_q    <= sck_s1_d;
            sck_s2_q    <= sck_s2_d;
            sck_h_q     <= sck_h_d;
            mosi_s1_q   <= mosi_s1_d;
            mosi_s2_q   <= mosi_s2_d;
            settle_q    <= settle_d;
            armed_q     <= armed_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            tx_sr_q     <= tx_sr_d;
            rx_sr_q     <= rx_sr_d;
            rx_bytes_q  <= rx_bytes_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rx_bytes  = rx_bytes_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != ST_IDLE);
    assign miso      = tx_sr_q[SIZE-1];

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - randomized scoreboard bench for spi_slave
module tb_spi_slave;

    localparam int SIZE = 40;
    localparam int HALF = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [SIZE-1:0] tx_bytes;
    logic            tx_load;
    logic [SIZE-1:0] rx_bytes;
    logic            rx_valid;
    logic            frame_err;
    logic            busy;
    logic            cs;
    logic            sck;
    logic            mosi;
    logic            miso;

    always #10 clk = ~clk;

    spi_slave #(.SIZE(SIZE)) dut (
        .clk       (clk),
        .reset     (reset),
        .tx_bytes  (tx_bytes),
        .tx_load   (tx_load),
        .rx_bytes  (rx_bytes),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy),
        .cs        (cs),
        .sck       (sck),
        .mosi      (mosi),
        .miso      (miso)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [SIZE-1:0] exp_rx_q[$];
    logic [SIZE-1:0] exp_err_q[$];
    logic [SIZE-1:0] model_pend;
    logic [SIZE-1:0] model_rx;
    logic [SIZE-1:0] mon_e;
    logic            err_prev = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    // monitor: pops the scoreboard whenever the DUT pulses rx_valid or frame_err
    always @(negedge clk) begin
        if (reset) begin
            err_prev = 1'b0;
        end else begin
            if (err_prev) chk("frame_err width", {63'd0, frame_err}, 64'd0);
            if (rx_valid) begin
                if (exp_rx_q.size() == 0) begin
                    chk("rx_valid spurious", {63'd0, rx_valid}, 64'd0);
                end else begin
                    mon_e = exp_rx_q.pop_front();
                    chk("rx_bytes", {24'd0, rx_bytes}, {24'd0, mon_e});
                end
            end
            if (frame_err && !err_prev) begin
                if (exp_err_q.size() == 0) begin
                    chk("frame_err spurious", {63'd0, frame_err}, 64'd0);
                end else begin
                    mon_e = exp_err_q.pop_front();
                    chk("rx_bytes held on abort", {24'd0, rx_bytes}, {24'd0, mon_e});
                    chk("rx_valid on abort", {63'd0, rx_valid}, 64'd0);
                end
            end
            err_prev = frame_err;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic do_load(input logic [SIZE-1:0] v);
        tx_bytes = v;
        tx_load  = 1'b1;
        @(negedge clk);
        tx_load  = 1'b0;
        model_pend = v;
    endtask

    task automatic bit_cycle(input logic b, output logic m);
        mosi = b;
        repeat (HALF) @(negedge clk);
        m = miso;
        sck = 1'b1;
        repeat (HALF) @(negedge clk);
        sck = 1'b0;
    endtask

    // one cs window of nbits sck pulses; expectations come from the pending-word model
    task automatic spi_frame(input logic [SIZE-1:0] data, input int nbits, input int load_at,
                             input logic [SIZE-1:0] load_val, input string tag);
        logic [63:0]     mb;
        logic [63:0]     em;
        logic [SIZE-1:0] snap;
        logic            m;
        mb   = '0;
        em   = '0;
        snap = model_pend;
        if (nbits >= SIZE) exp_rx_q.push_back(data);
        else exp_err_q.push_back(model_rx);
        for (int k = 0; k < nbits; k++) em = {em[62:0], (k < SIZE) ? snap[SIZE-1-k] : 1'b0};
        @(negedge clk);
        cs = 1'b0;
        for (int k = 0; k < nbits; k++) begin
            if (k == load_at) do_load(load_val);
            bit_cycle((k < SIZE) ? data[SIZE-1-k] : 1'b1, m);
            mb = {mb[62:0], m};
            if (k == 0) chk({tag, " busy in frame"}, {63'd0, busy}, 64'd1);
        end
        repeat (HALF) @(negedge clk);
        cs   = 1'b1;
        mosi = 1'b0;
        repeat (2 * HALF) @(negedge clk);
        chk({tag, " miso stream"}, mb, em);
        chk({tag, " busy after"}, {63'd0, busy}, 64'd0);
        if (nbits >= SIZE) model_rx = data;
    endtask

    function automatic logic [SIZE-1:0] rnd_word();
        logic [63:0] w;
        w = {$urandom, $urandom};
        return w[SIZE-1:0];
    endfunction

    initial begin
        logic            m;
        logic            acc;
        logic [SIZE-1:0] d;
        logic [SIZE-1:0] lv;
        int              nb;
        int              la;

        reset = 1'b1; cs = 1'b1; sck = 1'b0; mosi = 1'b0;
        tx_load = 1'b0; tx_bytes = '0;
        model_pend = '0; model_rx = '0;
        repeat (4) @(negedge clk);
        chk("reset outputs", {20'd0, rx_bytes, rx_valid, frame_err, busy, miso}, 64'd0);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        do_load(40'hA5_0F_F0_12_34);
        repeat (4) @(negedge clk);
        spi_frame(40'h80_01_02_03_04, SIZE, -1, '0, "basic");

        do_load(40'h11_1111_1111);
        repeat (4) @(negedge clk);
        spi_frame(rnd_word(), SIZE, 20, 40'h22_2222_2222, "b2b1");
        spi_frame(rnd_word(), SIZE, -1, '0, "b2b2");
        spi_frame(rnd_word(), SIZE, -1, '0, "b2b3");

        spi_frame(rnd_word(), 17, -1, '0, "abort");
        spi_frame(rnd_word(), SIZE, -1, '0, "after abort");

        spi_frame(rnd_word(), 44, -1, '0, "extra clocks");

        @(negedge clk);
        cs = 1'b0;
        for (int k = 0; k < 10; k++) bit_cycle(1'($urandom), m);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid reset outputs", {20'd0, rx_bytes, rx_valid, frame_err, busy, miso}, 64'd0);
        reset = 1'b0;
        model_pend = '0;
        model_rx   = '0;
        acc = 1'b0;
        for (int k = 0; k < 30; k++) begin
            bit_cycle(1'($urandom), m);
            acc = acc | busy | m;
        end
        chk("no rejoin after reset", {63'd0, acc}, 64'd0);
        repeat (HALF) @(negedge clk);
        cs = 1'b1;
        repeat (2 * HALF) @(negedge clk);
        spi_frame('1, SIZE, -1, '0, "post reset");

        acc = 1'b0;
        for (int k = 0; k < 20; k++) begin
            sck = ~sck;
            mosi = 1'($urandom);
            repeat (HALF) @(negedge clk);
            acc = acc | busy | miso;
        end
        sck = 1'b0;
        repeat (2 * HALF) @(negedge clk);
        chk("idle noise miso/busy", {63'd0, acc}, 64'd0);

        for (int i = 0; i < 8; i++) begin
            d  = rnd_word();
            lv = rnd_word();
            if ($urandom_range(0, 1) == 1) begin
                do_load(rnd_word());
                repeat (4) @(negedge clk);
            end
            nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, SIZE - 1)) : SIZE;
            la = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 16)) : -1;
            if (la >= nb) la = -1;
            spi_frame(d, nb, la, lv, "random");
        end

        repeat (10) @(negedge clk);
        chk("rx pulses outstanding", 64'(exp_rx_q.size()), 64'd0);
        chk("err pulses outstanding", 64'(exp_err_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
